bcd_updown_counter_n: RTL and testbench



---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit.sv | 58 +++++
 rtl/bcd_updown_counter_n.sv | 102 ++++++++++
 tb/tb_bcd_updown_counter_n.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the multi-digit BCD up/down counter.
//   BCD_MAX / BCD_MIN : legal limits of one decimal digit
//   bcd_digit_t       : one packed BCD nibble
//   bcd_valid()       : true when a nibble holds a legal decimal digit
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell of the BCD counter.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   clr          : synchronous clear to 0 (highest priority)
//   load, ld_val : synchronous load of an already-sanitised BCD digit
//   step         : advance one position in the direction given by up
//   up           : 1 = increment, 0 = decrement
//   digit        : registered digit value
//   term         : digit sits at the terminal value for the current direction
module bcd_digit
  import bcd_pkg::*;
#(
  parameter bcd_digit_t RST_DIGIT = BCD_MIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       up,
  output logic [3:0] digit,
  output logic       term
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = ld_val;
    end else if (step) begin
      // Out-of-range comparisons fold any illegal value back into 0..9,
      // so the cell can never step into a non-BCD code.
      if (up) begin
        digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN || digit_q > BCD_MAX) ? BCD_MAX
                                                            : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_q <= RST_DIGIT;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign term  = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Parametrised multi-digit BCD up/down counter.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-low reset
//   en          : count enable
//   up          : 1 = increment, 0 = decrement
//   sat         : 1 = hold at the terminal value, 0 = wrap around
//   clr         : synchronous clear (beats load and en)
//   load, din   : synchronous load of packed BCD; illegal nibbles load as 0
//   count       : registered packed BCD count, digit 0 in bits [3:0]
//   wrap        : registered, high for one cycle after a wrap transition
//   load_err    : registered, high for one cycle after a load with a bad nibble
//   ripple_out  : en & count at terminal value; drives en of a next stage
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int                    DIGITS  = 4,
  parameter logic [4*DIGITS-1:0]   RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  load_err,
  output logic                  ripple_out
);

  logic [DIGITS-1:0]   term;
  logic [DIGITS-1:0]   step;
  logic [DIGITS-1:0]   nib_bad;
  logic [4*DIGITS-1:0] ld_val;
  // lower_term[i] = every digit below i is at its terminal value.
  logic [DIGITS:0]     lower_term;
  logic                all_term;
  logic                hold_at_limit;

  logic wrap_q, wrap_d;
  logic load_err_q, load_err_d;

  assign lower_term[0] = 1'b1;
  assign all_term      = lower_term[DIGITS];
  assign hold_at_limit = sat & all_term;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib_bad[gi]           = ~bcd_valid(din[4*gi +: 4]);
      assign ld_val[4*gi +: 4]     = nib_bad[gi] ? BCD_MIN : din[4*gi +: 4];
      assign lower_term[gi+1]      = lower_term[gi] & term[gi];
      // In saturate mode the whole counter freezes at its limit, so
      // suppress every digit's step rather than letting the chain wrap.
      assign step[gi]              = en & lower_term[gi] & ~hold_at_limit;

      bcd_digit #(
        .RST_DIGIT (RST_VAL[4*gi +: 4])
      ) u_digit (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .load   (load),
        .ld_val (ld_val[4*gi +: 4]),
        .step   (step[gi]),
        .up     (up),
        .digit  (count[4*gi +: 4]),
        .term   (term[gi])
      );
    end
  endgenerate

  always_comb begin
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
    end else if (load) begin
      load_err_d = |nib_bad;
    end else if (en && all_term && !sat) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap       = wrap_q;
  assign load_err   = load_err_q;
  assign ripple_out = en & all_term;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
module tb_bcd_updown_counter_n;

  logic       clk;
  logic       reset;
  logic       en, up, sat, clr, load;
  logic [7:0] din;
  logic [7:0] count;
  logic       wrap, load_err, ripple_out;

  // Cascade pair: two single-digit counters, low ripple_out -> high en
  logic       c_en, c_up, c_sat, c_clr, c_load;
  logic [3:0] c_din;
  logic [3:0] lo_count, hi_count;
  logic       lo_wrap, hi_wrap, lo_lerr, hi_lerr, lo_ripple, hi_ripple;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: the count as a plain integer 0..99
  int   model_v;
  int   next_v;
  logic exp_wrap, exp_lerr, exp_ripple;

  bcd_updown_counter_n #(.DIGITS(2), .RST_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .clr(clr),
    .load(load), .din(din), .count(count), .wrap(wrap),
    .load_err(load_err), .ripple_out(ripple_out)
  );

  bcd_updown_counter_n #(.DIGITS(1), .RST_VAL(4'h0)) u_lo (
    .clk(clk), .reset(reset), .en(c_en), .up(c_up), .sat(c_sat),
    .clr(c_clr), .load(c_load), .din(c_din), .count(lo_count),
    .wrap(lo_wrap), .load_err(lo_lerr), .ripple_out(lo_ripple)
  );

  bcd_updown_counter_n #(.DIGITS(1), .RST_VAL(4'h0)) u_hi (
    .clk(clk), .reset(reset), .en(lo_ripple), .up(c_up), .sat(c_sat),
    .clr(c_clr), .load(c_load), .din(c_din), .count(hi_count),
    .wrap(hi_wrap), .load_err(hi_lerr), .ripple_out(hi_ripple)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  // Apply inputs and compute what the next edge must produce.
  task automatic set_inputs(input logic i_en, input logic i_up, input logic i_sat,
                            input logic i_clr, input logic i_load,
                            input logic [7:0] i_din);
    int hi, lo;
    en = i_en; up = i_up; sat = i_sat; clr = i_clr; load = i_load; din = i_din;
    exp_ripple = i_en && (i_up ? (model_v == 99) : (model_v == 0));
    next_v = model_v; exp_wrap = 1'b0; exp_lerr = 1'b0;
    if (i_clr) begin
      next_v = 0;
    end else if (i_load) begin
      hi = int'(i_din[7:4]);
      lo = int'(i_din[3:0]);
      exp_lerr = (hi > 9) || (lo > 9);
      next_v = ((hi > 9) ? 0 : hi) * 10 + ((lo > 9) ? 0 : lo);
    end else if (i_en) begin
      if (i_up) begin
        if (model_v == 99) begin
          next_v = i_sat ? 99 : 0;
          exp_wrap = !i_sat;
        end else next_v = model_v + 1;
      end else begin
        if (model_v == 0) begin
          next_v = i_sat ? 0 : 99;
          exp_wrap = !i_sat;
        end else next_v = model_v - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_v = next_v;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 0; up = 1; sat = 0; clr = 0; load = 0; din = 8'h00;
    c_en = 0; c_up = 1; c_sat = 0; c_clr = 0; c_load = 0; c_din = 4'h0;
    model_v = 0;
    #12;
    checks++;
    if (count !== 8'h00 || wrap !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state count=%h wrap=%b lerr=%b required 00 0 0", count, wrap, load_err);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_inputs(0, 1, 0, 0, 0, 8'h00);
      tick();
      checks++;
      if (count !== to_bcd(model_v) || wrap !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold count=%h wrap=%b required %h 0", count, wrap, to_bcd(model_v));
      end
    end
    $display("test_reset done count=%h", count);
  endtask

  task automatic test_up_wrap();
    set_inputs(0, 1, 0, 0, 1, 8'h97);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_inputs(1, 1, 0, 0, 0, 8'h00);
      #1;
      checks++;
      if (ripple_out !== exp_ripple) begin
        failures++;
        $display("FAIL up_ripple count=%h ripple=%b required %b", count, ripple_out, exp_ripple);
      end
      tick();
      checks++;
      if (count !== to_bcd(model_v) || wrap !== exp_wrap) begin
        failures++;
        $display("FAIL up_wrap count=%h wrap=%b required %h %b", count, wrap, to_bcd(model_v), exp_wrap);
      end
      $display("up_wrap edge %0d count=%h wrap=%b", i, count, wrap);
    end
  endtask

  task automatic test_down_sat();
    set_inputs(0, 0, 1, 0, 1, 8'h02);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_inputs(1, 0, 1, 0, 0, 8'h00);
      #1;
      checks++;
      if (ripple_out !== exp_ripple) begin
        failures++;
        $display("FAIL down_ripple count=%h ripple=%b required %b", count, ripple_out, exp_ripple);
      end
      tick();
      checks++;
      if (count !== to_bcd(model_v) || wrap !== 1'b0) begin
        failures++;
        $display("FAIL down_sat count=%h wrap=%b required %h 0", count, wrap, to_bcd(model_v));
      end
      $display("down_sat edge %0d count=%h wrap=%b", i, count, wrap);
    end
  endtask

  task automatic test_load();
    set_inputs(1, 1, 0, 0, 1, 8'h5C);
    tick();
    checks++;
    if (count !== 8'h50 || load_err !== 1'b1) begin
      failures++;
      $display("FAIL load_bad_nibble count=%h lerr=%b required 50 1", count, load_err);
    end
    set_inputs(0, 1, 0, 0, 0, 8'h00);
    tick();
    checks++;
    if (count !== 8'h50 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL load_err_one_cycle count=%h lerr=%b required 50 0", count, load_err);
    end
    set_inputs(1, 1, 0, 1, 1, 8'h5C);
    tick();
    checks++;
    if (count !== 8'h00 || load_err !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL clr_over_load count=%h lerr=%b wrap=%b required 00 0 0", count, load_err, wrap);
    end
    $display("test_load done count=%h", count);
  endtask

  task automatic test_dir_flip();
    logic u;
    set_inputs(0, 1, 0, 0, 1, 8'h10);
    tick();
    u = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_inputs(1, u, 0, 0, 0, 8'h00);
      tick();
      checks++;
      if (count !== to_bcd(model_v)) begin
        failures++;
        $display("FAIL dir_flip count=%h required %h", count, to_bcd(model_v));
      end
      $display("dir_flip edge %0d up=%b count=%h", i, u, count);
      u = ~u;
    end
    // Start an increment, then reset between edges
    set_inputs(1, 1, 0, 0, 0, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    model_v = 0;
    checks++;
    if (count !== 8'h00 || wrap !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%h wrap=%b lerr=%b required 00 0 0", count, wrap, load_err);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("async_reset count=%h", count);
  endtask

  task automatic test_random();
    logic r_en, r_up, r_sat, r_clr, r_load;
    logic [7:0] r_din;
    for (int i = 0; i < 60; i++) begin
      r_en   = 1'($urandom_range(0, 3) != 0);
      r_up   = 1'($urandom_range(0, 1));
      r_sat  = 1'($urandom_range(0, 1));
      r_clr  = 1'($urandom_range(0, 15) == 0);
      r_load = 1'($urandom_range(0, 5) == 0);
      r_din  = 8'($urandom);
      // Bias toward the limits so wrap/saturate paths get exercised
      if ($urandom_range(0, 1) == 1) r_din = ($urandom_range(0, 1) == 1) ? 8'h99 : 8'h00;
      set_inputs(r_en, r_up, r_sat, r_clr, r_load, r_din);
      #1;
      checks++;
      if (ripple_out !== exp_ripple) begin
        failures++;
        $display("FAIL rand_ripple it=%0d ripple=%b required %b", i, ripple_out, exp_ripple);
      end
      tick();
      checks++;
      if (count !== to_bcd(model_v) || wrap !== exp_wrap || load_err !== exp_lerr) begin
        failures++;
        $display("FAIL rand_step it=%0d count=%h wrap=%b lerr=%b required %h %b %b",
                 i, count, wrap, load_err, to_bcd(model_v), exp_wrap, exp_lerr);
      end
      $display("rand it=%0d en=%b up=%b sat=%b clr=%b load=%b din=%h count=%h",
               i, r_en, r_up, r_sat, r_clr, r_load, r_din, count);
    end
  endtask

  task automatic test_cascade();
    logic [7:0] exp;
    set_inputs(0, 1, 0, 0, 0, 8'h00);
    checks++;
    if ({hi_count, lo_count} !== 8'h00) begin
      failures++;
      $display("FAIL cascade_start count=%h required 00", {hi_count, lo_count});
    end
    c_en = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      #1;
      exp = to_bcd(n);
      checks++;
      if ({hi_count, lo_count} !== exp || lo_wrap !== (n % 10 == 0)) begin
        failures++;
        $display("FAIL cascade n=%0d count=%h lo_wrap=%b required %h %b",
                 n, {hi_count, lo_count}, lo_wrap, exp, (n % 10 == 0));
      end
      $display("cascade edge %0d count=%h", n, {hi_count, lo_count});
    end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_load();
    test_dir_flip();
    test_random();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
